// File: rtl/gpu_lram_arb.sv
// Local RAM arbiter: external gateway, load/store and instruction fetch share one
// single-port RAM; fetched long-words feed a 4-deep halfword instruction FIFO.
module gpu_lram_arb #(
  parameter int AW     = 10,
  parameter int STARVE = 4
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          ext_req,
  input  logic          ext_rw,
  input  logic [AW-1:0] ext_addr,
  input  logic [31:0]   ext_wdata,
  output logic          ext_ack,
  output logic [31:0]   ext_rdata,
  output logic          ext_rvalid,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic          ls_ack,
  output logic [31:0]   ls_rdata,
  output logic          ls_rvalid,
  input  logic          pc_load,
  input  logic [AW:0]   pc_val,
  input  logic          ins_take,
  output logic          insrdy,
  output logic [15:0]   ins_out,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);
  localparam int SW = $clog2(STARVE + 1);

  logic [SW-1:0]    starve_q, starve_d;
  logic [AW-1:0]    fpc_q, fpc_d;
  logic             fen_q, fen_d, skip_q, skip_d, infl_q, erv_q, lrv_q;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       rp_q, rp_d, wp_q, wp_d;
  logic [3:0][15:0] fifo_q, fifo_d;
  logic             elig, force_f, gnt_e, gnt_l, gnt_f;
  logic             pop, ret, push1, push2;

  // A fetch is only issued when its two halfwords are guaranteed to fit on return.
  assign elig    = !pc_load && fen_q &&
                   (({1'b0, cnt_q} + {2'b00, infl_q, 1'b0}) <= 4'd2);
  assign force_f = elig && (starve_q == SW'(STARVE));
  assign gnt_e   = !reset && ext_req && !force_f;
  assign gnt_l   = !reset && ls_req && !ext_req && !force_f;
  assign gnt_f   = !reset && elig && (force_f || (!ext_req && !ls_req));

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (gnt_e) begin
      ram_addr  = ext_addr;
      ram_wdata = ext_wdata;
      ram_we    = !ext_rw;
    end else if (gnt_l) begin
      ram_addr  = ls_addr;
      ram_wdata = ls_wdata;
      ram_we    = ls_we;
    end else if (gnt_f) begin
      ram_addr  = fpc_q;
    end
  end

  assign ram_cs     = gnt_e | gnt_l | gnt_f;
  assign ext_ack    = gnt_e;
  assign ls_ack     = gnt_l;
  // Read returns are suppressed while reset is held so a cancelled access never surfaces.
  assign ext_rvalid = erv_q && !reset;
  assign ls_rvalid  = lrv_q && !reset;
  assign ext_rdata  = ext_rvalid ? ram_rdata : '0;
  assign ls_rdata   = ls_rvalid ? ram_rdata : '0;
  assign insrdy     = (cnt_q != 3'd0);
  assign ins_out    = insrdy ? fifo_q[rp_q] : '0;

  assign pop   = ins_take && insrdy;
  assign ret   = infl_q && !pc_load;
  assign push1 = ret && skip_q;
  assign push2 = ret && !skip_q;

  always_comb begin
    fifo_d = fifo_q;
    rp_d   = rp_q;
    wp_d   = wp_q;
    cnt_d  = cnt_q;
    fpc_d  = fpc_q;
    skip_d = skip_q;
    fen_d  = fen_q;
    if (pc_load) begin
      rp_d   = 2'd0;
      wp_d   = 2'd0;
      cnt_d  = 3'd0;
      fpc_d  = pc_val[AW:1];
      skip_d = pc_val[0];
      fen_d  = 1'b1;
    end else begin
      if (pop) rp_d = rp_q + 2'd1;
      if (push1) begin
        fifo_d[wp_q] = ram_rdata[15:0];
        wp_d         = wp_q + 2'd1;
        skip_d       = 1'b0;
      end
      if (push2) begin
        // big-endian: upper halfword is the earlier instruction
        fifo_d[wp_q]        = ram_rdata[31:16];
        fifo_d[wp_q + 2'd1] = ram_rdata[15:0];
        wp_d                = wp_q + 2'd2;
      end
      cnt_d = cnt_q + {1'b0, push2, push1} - {2'b00, pop};
      if (gnt_f) fpc_d = fpc_q + 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt_f || !elig)              starve_d = '0;
    else if (starve_q != SW'(STARVE)) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      starve_q <= '0;
      fpc_q    <= '0;
      fen_q    <= 1'b0;
      skip_q   <= 1'b0;
      infl_q   <= 1'b0;
      erv_q    <= 1'b0;
      lrv_q    <= 1'b0;
      cnt_q    <= 3'd0;
      rp_q     <= 2'd0;
      wp_q     <= 2'd0;
      fifo_q   <= '0;
    end else begin
      starve_q <= starve_d;
      fpc_q    <= fpc_d;
      fen_q    <= fen_d;
      skip_q   <= skip_d;
      infl_q   <= gnt_f;
      erv_q    <= gnt_e && ext_rw;
      lrv_q    <= gnt_l && !ls_we;
      cnt_q    <= cnt_d;
      rp_q     <= rp_d;
      wp_q     <= wp_d;
      fifo_q   <= fifo_d;
    end
  end
endmodule

// File: tb/tb_gpu_lram_arb.sv
// Bench for gpu_lram_arb: arbitration table, directed fetch/flush/starve/reset
// sequences, then random traffic against a queue-based reference model.
module tb_gpu_lram_arb;
  localparam int AW = 10, STARVE = 4;

  logic          sys_clk = 1'b0, reset;
  logic          ext_req, ext_rw, ext_ack, ext_rvalid;
  logic [AW-1:0] ext_addr, ls_addr, ram_addr;
  logic [31:0]   ext_wdata, ext_rdata, ls_wdata, ls_rdata, ram_wdata, ram_rdata;
  logic          ls_req, ls_we, ls_ack, ls_rvalid;
  logic          pc_load, ins_take, insrdy, ram_cs, ram_we;
  logic [AW:0]   pc_val;
  logic [15:0]   ins_out;

  always #5 sys_clk = ~sys_clk;

  gpu_lram_arb #(.AW(AW), .STARVE(STARVE)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .ext_req(ext_req), .ext_rw(ext_rw), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_rvalid(ls_rvalid),
    .pc_load(pc_load), .pc_val(pc_val), .ins_take(ins_take),
    .insrdy(insrdy), .ins_out(ins_out),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Reference model: instruction stream as a queue of halfwords, grant by priority rule.
  logic [15:0] mq[$];
  bit          m_en, m_skip, m_pend, m_erv, m_lrv;
  int          m_fpc, m_starve, m_g;
  int          n_vec, n_err;

  typedef struct {
    logic          ereq, erw;
    logic [AW-1:0] eaddr;
    logic [31:0]   ewd;
    logic          lreq, lwe;
    logic [AW-1:0] laddr;
    logic [31:0]   lwd, rrd;
    logic          cs, we;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          eack, lack, erv, lrv;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_elig();
    return !pc_load && m_en && (mq.size() + 2 * int'(m_pend) <= 2);
  endfunction

  // 0 none, 1 ext, 2 ls, 3 fetch
  function automatic int m_grant();
    if (reset) return 0;
    if (m_elig() && m_starve == STARVE) return 3;
    if (ext_req) return 1;
    if (ls_req) return 2;
    if (m_elig()) return 3;
    return 0;
  endfunction

  task automatic model_check(input int g);
    chk("ram_cs", 32'(ram_cs), 32'(g != 0));
    chk("ram_we", 32'(ram_we), 32'((g == 1 && !ext_rw) || (g == 2 && ls_we)));
    if (g == 1) chk("ram_addr", 32'(ram_addr), 32'(ext_addr));
    if (g == 2) chk("ram_addr", 32'(ram_addr), 32'(ls_addr));
    if (g == 3) chk("ram_addr", 32'(ram_addr), m_fpc);
    if (g == 1 && !ext_rw) chk("ram_wdata", ram_wdata, ext_wdata);
    if (g == 2 && ls_we)   chk("ram_wdata", ram_wdata, ls_wdata);
    chk("ext_ack", 32'(ext_ack), 32'(g == 1));
    chk("ls_ack", 32'(ls_ack), 32'(g == 2));
    chk("ext_rvalid", 32'(ext_rvalid), 32'(m_erv && !reset));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(m_lrv && !reset));
    if (m_erv && !reset) chk("ext_rdata", ext_rdata, ram_rdata);
    if (m_lrv && !reset) chk("ls_rdata", ls_rdata, ram_rdata);
    chk("insrdy", 32'(insrdy), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("ins_out", 32'(ins_out), 32'(mq[0]));
  endtask

  task automatic model_update(input int g);
    bit el;
    if (reset) begin
      mq.delete();
      m_en = 0; m_skip = 0; m_pend = 0; m_erv = 0; m_lrv = 0;
      m_fpc = 0; m_starve = 0;
      return;
    end
    el    = m_elig();
    m_erv = (g == 1) && ext_rw;
    m_lrv = (g == 2) && !ls_we;
    if (ins_take && mq.size() != 0) void'(mq.pop_front());
    if (m_pend && !pc_load) begin
      if (m_skip) begin
        mq.push_back(ram_rdata[15:0]);
        m_skip = 0;
      end else begin
        mq.push_back(ram_rdata[31:16]);
        mq.push_back(ram_rdata[15:0]);
      end
    end
    if (pc_load) begin
      mq.delete();
      m_fpc  = int'(pc_val) / 2;
      m_skip = pc_val[0];
      m_en   = 1;
    end
    m_pend = (g == 3);
    if (g == 3) m_fpc = (m_fpc + 1) % (1 << AW);
    if (g == 3 || !el) m_starve = 0;
    else if (m_starve < STARVE) m_starve++;
  endtask

  // Inputs are set by the caller just after a rising edge and held through the next one.
  task automatic tick();
    int g;
    #2;
    g = m_grant();
    model_check(g);
    @(posedge sys_clk);
    #1;
    model_update(g);
    m_g = g;
  endtask

  task automatic idle_inputs();
    ext_req = 0; ext_rw = 0; ext_addr = '0; ext_wdata = '0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
    pc_load = 0; pc_val = '0; ins_take = 0; ram_rdata = '0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_g = 0;
    tbl[0] = '{1'b1, 1'b0, 10'h155, 32'h11223344, 1'b1, 1'b0, 10'h3FF, 32'h0, 32'h0,
               1'b1, 1'b1, 10'h155, 32'h11223344, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 10'h3FF, 32'h0, 32'h0,
               1'b1, 1'b0, 10'h3FF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0, 32'hCAFEF00D,
               1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 10'h001, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0, 32'h0,
               1'b1, 1'b0, 10'h001, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b1, 10'h002, 32'hA5A5A5A5, 32'h01020304,
               1'b1, 1'b1, 10'h002, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 10'h3FF, 32'h0, 1'b1, 1'b1, 10'h010, 32'h77, 32'h0,
               1'b1, 1'b0, 10'h3FF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b1, 10'h010, 32'h77, 32'h0BADF00D,
               1'b1, 1'b1, 10'h010, 32'h77, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0, 32'h0,
               1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};

    idle_inputs();
    reset = 1;
    repeat (2) @(posedge sys_clk);
    #1;
    model_update(0);
    ext_req = 1; ext_rw = 1;
    tick();
    #1;
    chk("rst.ext_ack", 32'(ext_ack), 0);
    chk("rst.ram_cs", 32'(ram_cs), 0);
    chk("rst.ram_we", 32'(ram_we), 0);
    chk("rst.ext_rvalid", 32'(ext_rvalid), 0);
    chk("rst.ls_rvalid", 32'(ls_rvalid), 0);
    chk("rst.insrdy", 32'(insrdy), 0);
    chk("rst.ins_out", 32'(ins_out), 0);
    tick();
    reset = 0; ext_req = 0;

    // arbitration table, fetch still disabled
    for (int i = 0; i < 8; i++) begin
      ext_req = tbl[i].ereq; ext_rw = tbl[i].erw; ext_addr = tbl[i].eaddr; ext_wdata = tbl[i].ewd;
      ls_req = tbl[i].lreq; ls_we = tbl[i].lwe; ls_addr = tbl[i].laddr; ls_wdata = tbl[i].lwd;
      ram_rdata = tbl[i].rrd;
      #1;
      chk($sformatf("tbl%0d.ram_cs", i), 32'(ram_cs), 32'(tbl[i].cs));
      chk($sformatf("tbl%0d.ram_we", i), 32'(ram_we), 32'(tbl[i].we));
      if (tbl[i].cs) chk($sformatf("tbl%0d.ram_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
      if (tbl[i].we) chk($sformatf("tbl%0d.ram_wdata", i), ram_wdata, tbl[i].wd);
      chk($sformatf("tbl%0d.ext_ack", i), 32'(ext_ack), 32'(tbl[i].eack));
      chk($sformatf("tbl%0d.ls_ack", i), 32'(ls_ack), 32'(tbl[i].lack));
      chk($sformatf("tbl%0d.ext_rvalid", i), 32'(ext_rvalid), 32'(tbl[i].erv));
      chk($sformatf("tbl%0d.ls_rvalid", i), 32'(ls_rvalid), 32'(tbl[i].lrv));
      if (tbl[i].erv) chk($sformatf("tbl%0d.ext_rdata", i), ext_rdata, tbl[i].rrd);
      if (tbl[i].lrv) chk($sformatf("tbl%0d.ls_rdata", i), ls_rdata, tbl[i].rrd);
      tick();
    end
    idle_inputs();

    // fetch start at halfword 0x010, big-endian fill, stall at 4 entries
    pc_load = 1; pc_val = 11'h010; #1;
    chk("f1.cs_on_load", 32'(ram_cs), 0); tick();
    pc_load = 0; #1;
    chk("f1.cs", 32'(ram_cs), 1); chk("f1.addr", 32'(ram_addr), 32'h008); tick();
    ram_rdata = 32'hAAAA5555; #1;
    chk("f1.addr2", 32'(ram_addr), 32'h009); chk("f1.insrdy0", 32'(insrdy), 0); tick();
    ram_rdata = 32'h1234ABCD; #1;
    chk("f1.insrdy", 32'(insrdy), 1); chk("f1.head", 32'(ins_out), 32'hAAAA);
    chk("f1.cs_wait", 32'(ram_cs), 0); tick();
    ram_rdata = 32'h0; #1;
    chk("f1.cs_full", 32'(ram_cs), 0); tick();
    ins_take = 1; #1;
    chk("f1.cs_stall", 32'(ram_cs), 0); chk("f1.pop0", 32'(ins_out), 32'hAAAA); tick();
    #1; chk("f1.pop1", 32'(ins_out), 32'h5555); tick();
    #1; chk("f1.pop2", 32'(ins_out), 32'h1234); chk("f1.addr3", 32'(ram_addr), 32'h00A); tick();
    #1; chk("f1.pop3", 32'(ins_out), 32'hABCD); tick();
    ins_take = 0;

    // odd start: only the low halfword of the first return is kept
    pc_load = 1; pc_val = 11'h011; tick();
    pc_load = 0; #1;
    chk("f2.addr", 32'(ram_addr), 32'h008); tick();
    ram_rdata = 32'hBEEFCAFE; #1;
    chk("f2.addr2", 32'(ram_addr), 32'h009); tick();
    ram_rdata = 32'h11112222; ins_take = 1; #1;
    chk("f2.head", 32'(ins_out), 32'hCAFE); tick();
    ins_take = 0; #1;
    chk("f2.next", 32'(ins_out), 32'h1111); tick();

    // pc_load in the return cycle with ins_take: flush wins, return dropped
    pc_load = 1; pc_val = 11'h100; tick();
    pc_load = 0; #1;
    chk("f3.addr", 32'(ram_addr), 32'h080); tick();
    pc_load = 1; pc_val = 11'h040; ins_take = 1; ram_rdata = 32'hDEADBEEF; #1;
    chk("f3.cs_load", 32'(ram_cs), 0); tick();
    pc_load = 0; ins_take = 0; #1;
    chk("f3.flushed", 32'(insrdy), 0); chk("f3.newaddr", 32'(ram_addr), 32'h020); tick();
    ram_rdata = 32'h5A5A0F0F; #1;
    chk("f3.addr2", 32'(ram_addr), 32'h021); tick();
    #1; chk("f3.head", 32'(ins_out), 32'h5A5A); tick();

    // starvation: ext and ls held, fetch forced on the fifth lost cycle
    pc_load = 1; pc_val = 11'h000;
    ext_req = 1; ext_rw = 0; ext_addr = 10'h123; ext_wdata = 32'h600DF00D;
    ls_req = 1; ls_we = 0; ls_addr = 10'h200; #1;
    chk("st.load_ack", 32'(ext_ack), 1); tick();
    pc_load = 0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk($sformatf("st%0d.ext_ack", k), 32'(ext_ack), 32'(k != 5));
      chk($sformatf("st%0d.ls_ack", k), 32'(ls_ack), 0);
      if (k == 5) chk("st5.fetch_addr", 32'(ram_addr), 32'h000);
      tick();
    end
    ext_req = 0; #1;
    chk("st.ls_ack", 32'(ls_ack), 1); tick();
    ls_req = 0; #1;
    chk("st.ls_rvalid", 32'(ls_rvalid), 1); tick();

    // fpc wrap, then reset during an ext read
    pc_load = 1; pc_val = 11'h7FE; tick();
    pc_load = 0; #1;
    chk("w.addr", 32'(ram_addr), 32'h3FF); tick();
    #1; chk("w.wrap", 32'(ram_addr), 32'h000); chk("w.cs", 32'(ram_cs), 1); tick();
    ext_req = 1; ext_rw = 1; ext_addr = 10'h005; #1;
    chk("w.ext_ack", 32'(ext_ack), 1); tick();
    ext_req = 0; reset = 1; #1;
    chk("w.rst_rvalid", 32'(ext_rvalid), 0); tick();
    reset = 0; #1;
    chk("w.ram_cs", 32'(ram_cs), 0); chk("w.ram_we", 32'(ram_we), 0);
    chk("w.ext_rvalid", 32'(ext_rvalid), 0); chk("w.ls_rvalid", 32'(ls_rvalid), 0);
    chk("w.insrdy", 32'(insrdy), 0); chk("w.ins_out", 32'(ins_out), 0);
    chk("w.ext_rdata", ext_rdata, 0);
    tick();

    // random traffic; requesters hold their request until acked
    for (int c = 0; c < 3000; c++) begin
      if (!ext_req || m_g == 1) begin
        ext_req = ($urandom_range(0, 2) == 0);
        ext_rw = 1'($urandom_range(0, 1));
        ext_addr = AW'($urandom); ext_wdata = $urandom;
      end
      if (!ls_req || m_g == 2) begin
        ls_req = ($urandom_range(0, 1) == 0);
        ls_we = 1'($urandom_range(0, 1));
        ls_addr = AW'($urandom); ls_wdata = $urandom;
      end
      pc_load = ($urandom_range(0, 29) == 0);
      pc_val = (AW+1)'($urandom);
      ins_take = 1'($urandom_range(0, 1));
      ram_rdata = $urandom;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
